// File: rtl/network_sink_fifo_if.sv
// Bundles the network-side and host-side streams of network_sink_fifo.
// Both streams use valid/ready: a transfer happens on a rising clk edge where valid && ready; the source
// holds its payload stable while valid && !ready, and ready never depends combinationally on valid.
interface network_sink_fifo_if #(
  parameter int NUM_OUT   = 8,
  parameter int SNK_WIDTH = 16
);
  logic                 net_valid;
  logic                 net_last;
  logic                 net_ready;
  logic [NUM_OUT-1:0]   net_out;
  logic                 snk_ready;
  logic                 snk_valid;
  logic                 snk_last;
  logic [SNK_WIDTH-1:0] snk;

  modport master (
    output net_valid, net_last, net_out, snk_ready,
    input  net_ready, snk_valid, snk_last, snk
  );

  modport slave (
    input  net_valid, net_last, net_out, snk_ready,
    output net_ready, snk_valid, snk_last, snk
  );
endinterface

// File: rtl/network_sink_fifo.sv
// Buffers per-timestep network event vectors in a small FIFO and drains each entry as RUN/SPK/MSK words.
// Each entry yields an optional RUN word followed by one word per fired output (SPK) or nonzero chunk (MSK).
module network_sink_fifo #(
  parameter int NUM_OUT   = 8,
  parameter int RUN_WIDTH = 8,
  parameter int DEPTH     = 4,
  parameter int CHUNK     = 8,
  parameter int SNK_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       arstn,
  input  logic                       cfg_mask,
  network_sink_fifo_if.slave         bus,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int IDX_W   = $clog2(NUM_OUT);
  localparam int IDX_WS  = (IDX_W > 0) ? IDX_W : 1;
  localparam int NCHUNK  = (NUM_OUT + CHUNK - 1) / CHUNK;
  localparam int CIDX_W  = $clog2(NCHUNK);
  localparam int CIDX_WS = (CIDX_W > 0) ? CIDX_W : 1;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int OCC_W   = $clog2(DEPTH + 1);
  localparam int PAD_W   = NCHUNK * CHUNK;
  localparam int PL_W    = SNK_WIDTH - 2;

  localparam logic [OCC_W-1:0]     FULL    = OCC_W'(DEPTH);
  localparam logic [RUN_WIDTH-1:0] RUN_SAT = {RUN_WIDTH{1'b1}} - 1'b1;

  typedef struct packed {
    logic [NUM_OUT-1:0]   fires;
    logic [RUN_WIDTH-1:0] runs;
    logic                 send_run;
    logic                 last;
    logic                 mask;
  } entry_t;

  entry_t               mem [DEPTH];
  entry_t               new_entry;
  entry_t               head;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [OCC_W-1:0]     count;
  logic [RUN_WIDTH-1:0] run_cnt;
  logic                 run_done;
  logic [NUM_OUT-1:0]   sent;

  logic                 accept, is_event, push, pop, hs, empty;
  logic                 need_run, final_word;
  logic [PAD_W-1:0]     fires_pad;
  logic [NCHUNK-1:0]    chunk_nz;
  logic [NUM_OUT-1:0]   pend, sel_oh;
  logic [IDX_WS-1:0]    sel;
  logic [CIDX_WS-1:0]   sel_c;
  logic [CHUNK-1:0]     chunk_bits;
  logic [SNK_WIDTH-1:0] word;

  // Ingress: only timesteps with activity, a final step, or a saturating run create an entry.
  assign empty     = (count == '0);
  assign accept    = bus.net_valid && (count != FULL);
  assign is_event  = (|bus.net_out) || bus.net_last;
  assign push      = accept && (is_event || (run_cnt == RUN_SAT));

  always_comb begin
    new_entry.fires = bus.net_out;
    new_entry.mask  = cfg_mask;
    if (is_event) begin
      new_entry.runs     = run_cnt;
      new_entry.send_run = (run_cnt != '0) || bus.net_last;
      new_entry.last     = bus.net_last;
    end else begin
      new_entry.runs     = '1;
      new_entry.send_run = 1'b1;
      new_entry.last     = 1'b0;
    end
  end

  assign head      = mem[rd_ptr];
  assign need_run  = head.send_run && !run_done;
  assign fires_pad = PAD_W'(head.fires);

  always_comb begin
    chunk_nz = '0;
    for (int c = 0; c < NCHUNK; c++) begin
      chunk_nz[c] = |fires_pad[c*CHUNK +: CHUNK];
    end
    if (head.mask) pend = NUM_OUT'(chunk_nz & ~sent[NCHUNK-1:0]);
    else           pend = head.fires & ~sent;
  end

  // Lowest pending bit/chunk wins, so zero bits never cost a cycle.
  always_comb begin
    logic found;
    found  = 1'b0;
    sel    = '0;
    sel_oh = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (pend[i] && !found) begin
        found     = 1'b1;
        sel       = IDX_WS'(i);
        sel_oh[i] = 1'b1;
      end
    end
  end

  assign sel_c = sel[CIDX_WS-1:0];

  always_comb begin
    chunk_bits = '0;
    for (int c = 0; c < NCHUNK; c++) begin
      if (c == int'(sel)) chunk_bits = fires_pad[c*CHUNK +: CHUNK];
    end
  end

  assign final_word = need_run ? (pend == '0) : ((pend & ~sel_oh) == '0);

  always_comb begin
    word = '0;
    if (!empty) begin
      if (need_run)
        word = {2'd0, PL_W'(head.runs) << (PL_W - RUN_WIDTH)};
      else if (head.mask)
        word = {2'd2, ((PL_W'(sel_c) << CHUNK) | PL_W'(chunk_bits)) << (PL_W - CIDX_W - CHUNK)};
      else
        word = {2'd1, PL_W'(sel) << (PL_W - IDX_W)};
    end
  end

  assign hs            = !empty && bus.snk_ready;
  assign pop           = hs && final_word;
  assign bus.snk_valid = !empty;
  assign bus.snk       = word;
  assign bus.snk_last  = !empty && final_word && head.last;
  assign bus.net_ready = (count != FULL);
  assign occupancy     = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      run_cnt  <= '0;
      run_done <= 1'b0;
      sent     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        run_done <= 1'b0;
        sent     <= '0;
      end else if (hs) begin
        if (need_run) run_done <= 1'b1;
        else          sent     <= sent | sel_oh;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (accept) begin
        if (is_event)                run_cnt <= bus.net_last ? '0 : RUN_WIDTH'(1);
        else if (run_cnt == RUN_SAT) run_cnt <= '0;
        else                         run_cnt <= run_cnt + 1'b1;
      end
    end
  end
endmodule
